// File: rtl/mem_map_pkg.sv
// Address map, TSTAT bit layout and region decode shared by the data-side memory responder.
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h0000_1000;

  localparam logic [4:0] OFF_GPIO_OUT = 5'h00;
  localparam logic [4:0] OFF_GPIO_IN  = 5'h04;
  localparam logic [4:0] OFF_TCOUNT   = 5'h08;
  localparam logic [4:0] OFF_TCMP     = 5'h0C;
  localparam logic [4:0] OFF_TSTAT    = 5'h10;

  localparam int unsigned TSTAT_MATCH_BIT = 0;
  localparam int unsigned TSTAT_EN_BIT    = 1;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

  // MMIO occupies one 32-byte window; offsets past TSTAT read as zero.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input int unsigned ram_bytes);
    if ((addr - RAM_BASE) < 32'(ram_bytes)) return REG_RAM;
    if (addr[31:5] == MMIO_BASE[31:5]) return REG_MMIO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/timer_unit.sv
// Free-running compare timer with sticky match flag; CPU writes take priority over counting.
module timer_unit
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_cmp,
  input  logic        wr_stat,
  input  logic [31:0] write_data,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        en,
  output logic        match
);

  logic hit;
  assign hit = en && (count == cmp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      cmp   <= '0;
      en    <= 1'b0;
      match <= 1'b0;
    end else begin
      if (wr_count)  count <= write_data;
      else if (en)   count <= count + 32'd1;

      if (wr_cmp)    cmp <= write_data;
      if (wr_stat)   en  <= write_data[TSTAT_EN_BIT];

      // A new match outranks a same-cycle write-1-to-clear.
      if (hit)                                   match <= 1'b1;
      else if (wr_stat && write_data[TSTAT_MATCH_BIT]) match <= 1'b0;
    end
  end

endmodule

// File: rtl/data_memory_system.sv
// Data-port responder: word RAM plus GPIO and timer MMIO, combinational reads, clocked writes.
module data_memory_system
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned GPIO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       direction,
  input  logic [31:0]       write_data,
  input  logic              mem_write,
  output logic [31:0]       read_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]       mem [DEPTH];
  region_t           region;
  logic [4:0]        off;
  logic [AW-1:0]     ram_idx;
  logic [GPIO_W-1:0] sync1, sync2;
  logic              wr_ram, wr_mmio;
  logic              wr_gpio, wr_count, wr_cmp, wr_stat;
  logic [31:0]       t_count, t_cmp, tstat;
  logic              t_en, t_match;

  assign region  = decode_region(direction, DEPTH * 4);
  assign off     = {direction[4:2], 2'b00};
  assign ram_idx = direction[AW+1:2];

  // Stores are dropped entirely while reset is held, RAM included.
  assign wr_ram   = rst && mem_write && (region == REG_RAM);
  assign wr_mmio  = rst && mem_write && (region == REG_MMIO);
  assign wr_gpio  = wr_mmio && (off == OFF_GPIO_OUT);
  assign wr_count = wr_mmio && (off == OFF_TCOUNT);
  assign wr_cmp   = wr_mmio && (off == OFF_TCMP);
  assign wr_stat  = wr_mmio && (off == OFF_TSTAT);

  always_ff @(posedge clk) begin
    if (wr_ram) mem[ram_idx] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (wr_gpio) gpio_out <= write_data[GPIO_W-1:0];
    end
  end

  timer_unit u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (wr_count),
    .wr_cmp     (wr_cmp),
    .wr_stat    (wr_stat),
    .write_data (write_data),
    .count      (t_count),
    .cmp        (t_cmp),
    .en         (t_en),
    .match      (t_match)
  );

  assign timer_irq = t_match;

  always_comb begin
    tstat                  = '0;
    tstat[TSTAT_MATCH_BIT] = t_match;
    tstat[TSTAT_EN_BIT]    = t_en;
  end

  always_comb begin
    read_data = '0;
    case (region)
      REG_RAM:  read_data = mem[ram_idx];
      REG_MMIO: begin
        case (off)
          OFF_GPIO_OUT: read_data = 32'(gpio_out);
          OFF_GPIO_IN:  read_data = 32'(sync2);
          OFF_TCOUNT:   read_data = t_count;
          OFF_TCMP:     read_data = t_cmp;
          OFF_TSTAT:    read_data = tstat;
          default:      read_data = '0;
        endcase
      end
      default:  read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_data_memory_system.sv
// Directed bench for data_memory_system: RAM, GPIO, timer, unmapped space and reset behaviour.
module tb_data_memory_system;

  localparam logic [31:0] A_GPIO_OUT = 32'h1000;
  localparam logic [31:0] A_GPIO_IN  = 32'h1004;
  localparam logic [31:0] A_TCOUNT   = 32'h1008;
  localparam logic [31:0] A_TCMP     = 32'h100C;
  localparam logic [31:0] A_TSTAT    = 32'h1010;

  logic        clk;
  logic        rst;
  logic [31:0] direction;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        timer_irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] rd;

  data_memory_system #(.DEPTH(64), .GPIO_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .direction  (direction),
    .write_data (write_data),
    .mem_write  (mem_write),
    .read_data  (read_data),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    direction  = a;
    write_data = d;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    direction = a;
    mem_write = 1'b0;
    #1;
    d = read_data;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; direction = '0; write_data = '0; mem_write = 1'b0; gpio_in = '0;
    step(2);
    rst = 1'b1;

    check_eq("reset_gpio_out", 32'(gpio_out), 32'h0);
    check_eq("reset_irq", 32'(timer_irq), 32'h0);
    load(A_TCOUNT, rd); check_eq("reset_tcount", rd, 32'h0);
    load(A_TSTAT, rd);  check_eq("reset_tstat", rd, 32'h0);

    // RAM
    store(32'h0000_0010, 32'h1111_1111);
    store(32'h0000_0000, 32'h0000_CAFE);
    store(32'h0000_00FC, 32'h0BAD_F00D);
    direction = 32'h0000_0010; write_data = 32'hDEAD_BEEF; mem_write = 1'b1;
    #1;
    check_eq("ram_store_cycle_old", read_data, 32'h1111_1111);
    @(posedge clk); #1; mem_write = 1'b0;
    load(32'h0000_0010, rd); check_eq("ram_load_10", rd, 32'hDEAD_BEEF);
    load(32'h0000_0013, rd); check_eq("ram_load_13", rd, 32'hDEAD_BEEF);
    load(32'h0000_0000, rd); check_eq("ram_load_0", rd, 32'h0000_CAFE);
    load(32'h0000_00FC, rd); check_eq("ram_load_last", rd, 32'h0BAD_F00D);

    // GPIO
    store(A_GPIO_OUT, 32'h0000_A5A5);
    check_eq("gpio_out", 32'(gpio_out), 32'h0000_A5A5);
    load(A_GPIO_OUT, rd); check_eq("gpio_out_read", rd, 32'h0000_A5A5);
    gpio_in = 16'h1234;
    load(A_GPIO_IN, rd); check_eq("gpio_in_0edge", rd, 32'h0);
    step(1);
    load(A_GPIO_IN, rd); check_eq("gpio_in_1edge", rd, 32'h0);
    step(1);
    load(A_GPIO_IN, rd); check_eq("gpio_in_2edge", rd, 32'h0000_1234);
    store(A_GPIO_IN, 32'hFFFF_FFFF);
    load(A_GPIO_IN, rd); check_eq("gpio_in_ro", rd, 32'h0000_1234);

    // Timer match
    store(A_TCMP, 32'd5);
    store(A_TCOUNT, 32'd0);
    store(A_TSTAT, 32'h2);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      load(A_TCOUNT, rd); check_eq($sformatf("tcount_%0d", k), rd, 32'(k));
      check_eq($sformatf("irq_low_%0d", k), 32'(timer_irq), 32'h0);
    end
    step(1);
    check_eq("irq_match", 32'(timer_irq), 32'h1);
    load(A_TCOUNT, rd); check_eq("tcount_6", rd, 32'd6);
    load(A_TSTAT, rd);  check_eq("tstat_match_en", rd, 32'h3);
    store(A_TSTAT, 32'h3);
    check_eq("irq_cleared", 32'(timer_irq), 32'h0);
    load(A_TSTAT, rd);  check_eq("tstat_en_kept", rd, 32'h2);
    load(A_TCOUNT, rd); check_eq("tcount_7", rd, 32'd7);

    // Wrap
    store(A_TCOUNT, 32'hFFFF_FFFF);
    load(A_TCOUNT, rd); check_eq("tcount_max", rd, 32'hFFFF_FFFF);
    step(1);
    load(A_TCOUNT, rd); check_eq("tcount_wrap", rd, 32'h0);

    // Set wins over clear
    store(A_TCMP, 32'h100);
    store(A_TCOUNT, 32'h100);
    check_eq("irq_before_setwin", 32'(timer_irq), 32'h0);
    store(A_TSTAT, 32'h3);
    check_eq("irq_set_wins", 32'(timer_irq), 32'h1);
    load(A_TSTAT, rd); check_eq("tstat_set_wins", rd, 32'h3);
    store(A_TSTAT, 32'h1);
    check_eq("irq_clear_disable", 32'(timer_irq), 32'h0);
    load(A_TSTAT, rd); check_eq("tstat_disabled", rd, 32'h0);
    step(2);
    load(A_TCOUNT, rd); check_eq("tcount_hold", rd, 32'h102);

    // Unmapped
    store(32'h0000_2000, 32'hDEAD_DEAD);
    load(32'h0000_2000, rd); check_eq("unmapped_read", rd, 32'h0);
    load(32'h0000_0000, rd); check_eq("unmapped_no_alias", rd, 32'h0000_CAFE);
    load(A_TCMP, rd);        check_eq("unmapped_tcmp", rd, 32'h100);
    check_eq("unmapped_gpio", 32'(gpio_out), 32'h0000_A5A5);
    load(32'h0000_1014, rd); check_eq("mmio_hole_read", rd, 32'h0);

    // Reset mid-operation with a RAM store pending
    store(A_TSTAT, 32'h2);
    store(A_GPIO_OUT, 32'h0000_FFFF);
    check_eq("gpio_ffff", 32'(gpio_out), 32'h0000_FFFF);
    rst = 1'b0; direction = 32'h0000_0010; write_data = 32'h5555_5555; mem_write = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    check_eq("rst_gpio_out", 32'(gpio_out), 32'h0);
    check_eq("rst_irq", 32'(timer_irq), 32'h0);
    load(A_TCOUNT, rd);      check_eq("rst_tcount", rd, 32'h0);
    load(A_TCMP, rd);        check_eq("rst_tcmp", rd, 32'h0);
    load(A_TSTAT, rd);       check_eq("rst_tstat", rd, 32'h0);
    load(A_GPIO_IN, rd);     check_eq("rst_gpio_in", rd, 32'h0);
    load(32'h0000_0010, rd); check_eq("rst_ram_target", rd, 32'hDEAD_BEEF);
    load(32'h0000_0000, rd); check_eq("rst_ram_word0", rd, 32'h0000_CAFE);
    step(1);
    load(A_TCOUNT, rd);      check_eq("rst_timer_stopped", rd, 32'h0);
    load(32'h0000_00FC, rd); check_eq("rst_ram_last", rd, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_system.md
# data_memory_system

Data-side memory responder for the single-cycle processor. It answers the processor's data port (`direction`, `write_data`, `mem_write` in; `read_data` out) with a word-addressed RAM and a small memory-mapped peripheral region: a GPIO output register, a synchronized GPIO input and a compare timer. Reads are combinational so the processor completes loads in one cycle. Writes and all peripheral state update on the clock edge.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words; power of two, at most 1024.
- `GPIO_W`, 16: GPIO input and output width.
- `clk` in 1: system clock, shared with the processor.
- `rst` in 1: reset, synchronous and active-low.
- `direction` in 32: byte address from the processor ALU result.
- `write_data` in 32: store data.
- `mem_write` in 1: store strobe, sampled at the rising edge.
- `read_data` out 32: load data, combinational from `direction`.
- `gpio_in` in GPIO_W: asynchronous external inputs.
- `gpio_out` out GPIO_W: registered outputs.
- `timer_irq` out 1: registered sticky compare-match flag.

## Operation
- Address bits [1:0] are ignored; all accesses are full words.
- Address map:
  - RAM: 0x0000_0000 up to DEPTH*4-1, indexed by `direction[log2(DEPTH)+1:2]`.
  - MMIO base 0x0000_1000:
    - +0x0 GPIO_OUT, read/write.
    - +0x4 GPIO_IN, read-only, zero-extended.
    - +0x8 TCOUNT, read/write.
    - +0xC TCMP, read/write.
    - +0x10 TSTAT: bit0 MATCH (read, write-1-to-clear), bit1 EN (read/write), other bits read 0.
- Unmapped addresses read 0x0000_0000. Writes to them are ignored. Writes to GPIO_IN are ignored.
- Timer, when EN=1:
  - TCOUNT increments by 1 every cycle and wraps 0xFFFF_FFFF to 0.
  - When TCOUNT == TCMP, MATCH sets at the next edge.
  - When EN=0, TCOUNT holds and no match is detected.
- Simultaneous events:
  - A CPU write to TCOUNT overrides that cycle's increment.
  - A write-1-clear of MATCH in the same cycle as a new match event leaves MATCH=1 (set wins).
  - A TSTAT write updates EN and clears MATCH (when bit0=1) in the same edge.
- `timer_irq` equals MATCH.
- `gpio_in` passes through a two-flop synchronizer. GPIO_IN reads the second flop.

## Timing
- Read latency is 0 cycles: `read_data` is a function of `direction` and the current state.
- Write latency is 1 edge. A read of the same address in the write cycle returns the pre-write value.
- `gpio_out` and TCOUNT/TCMP/TSTAT change one edge after the store cycle.
- A `gpio_in` change is visible in GPIO_IN after 2 edges.
- MATCH sets on the edge following the cycle where TCOUNT == TCMP with EN=1.
- Reset, at any edge with `rst`=0:
  - `gpio_out`, TCOUNT, TCMP, EN, MATCH, `timer_irq` and the synchronizer flops become 0.
  - `mem_write` is ignored entirely, including RAM.
  - RAM contents are not reset and are preserved across reset.
- Reset asserted mid-count stops the timer at 0 with EN=0.

## Structure
- Package `mem_map_pkg` holds:
  - RAM base, MMIO base and register offsets as localparams.
  - The TSTAT bit positions.
  - An enum `region_t` {REG_RAM, REG_MMIO, REG_NONE} for the address decode.
- Sub-module `timer_unit`:
  - Inputs: clk, rst, the decoded write enables for TCOUNT/TCMP/TSTAT, and write_data.
  - Outputs: count, cmp, en, match.
- GPIO registers, the synchronizer, the RAM array and the read mux stay in the top module.

## Test plan
- RAM: store 0xDEADBEEF at 0x0000_0010, then load 0x0000_0010 (and 0x0000_0013) -> read_data=0xDEADBEEF. The store-cycle read of that address returns the old value.
- GPIO: store 0x0000_A5A5 to 0x1000 -> gpio_out=0xA5A5 after 1 edge. Drive gpio_in=0x1234 -> load 0x1004 returns 0x0000_1234 from the 2nd edge on.
- Timer match:
  - Write TCMP=5, TCOUNT=0, TSTAT=0x2. TCOUNT reaches 5 on the 5th edge after the TSTAT write; timer_irq=1 on the 6th edge.
  - Write TSTAT=0x3 -> MATCH clears and EN stays 1.
- Wrap and set-wins:
  - TCOUNT=0xFFFF_FFFF with EN=1 -> reads 0 one edge later.
  - With TCMP=TCOUNT, a write of TSTAT=0x3 in the match cycle -> MATCH=1.
- Unmapped: store to 0x0000_2000, then load it -> 0x0000_0000, and no RAM or MMIO state changes.
- Reset mid-operation: with the timer running and gpio_out=0xFFFF, assert rst=0 for 1 edge together with mem_write=1 to RAM.
  - Required: all registers read 0 and timer_irq=0.
  - Required: the targeted RAM word is unchanged and earlier RAM data is intact.
